spi_ram_responder: RTL and testbench
====================================

Name: spi_ram_responder

Overview:
- Synthesizable SPI target that answers the SPI RAM master in the SoC.
- Serial side is SPI mode 0. Command set is a 23LC1024-style subset: READ 0x03, WRITE 0x02, 24-bit address, sequential mode.
- Backed by an internal byte array. SCLK/CS_N/MOSI are oversampled in the clk domain, so no second clock is needed.
- Used as the RAM model in benches and as an on-chip scratch target; it can be swapped for the external PSRAM.

Parameters:
- ADDR_BITS, 8, byte-address width of the backing array (depth 2^ADDR_BITS); upper address bits are ignored.
- SYNC_STAGES, 2, flip-flop synchronizer depth on sclk, cs_n and mosi (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SCLK frequency.
- rst  input  1  synchronous, active-high reset.
- sclk  input  1  SPI clock from the master; idles low.
- cs_n  input  1  SPI chip select, active low.
- mosi  input  1  master out, slave in.
- miso  output  1  slave out, master in.
- busy  output  1  high while a synchronized cs_n is low.
- wr_strobe  output  1  one-clk pulse for each byte committed to the array.
- cmd_err  output  1  one-clk pulse when an unsupported command byte completes.

Behaviour:
- Reset: state=IDLE, miso=0, busy=0, wr_strobe=0, cmd_err=0, shift and bit counters cleared. Array contents are not reset.
- Synchronization and edge detection:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - A rise is prev=0 and cur=1 on synchronized sclk; a fall is the reverse.
  - A synchronized cs_n high at any time forces IDLE and miso=0 in the same cycle; edges seen in that cycle are ignored.
- States: IDLE, CMD, ADDR, WRITE, READ, IGNORE.
- IDLE: synchronized cs_n low -> CMD, bit count=0.
- CMD: shift mosi in MSB-first on each rise. At the 8th rise:
  - 0x03 -> ADDR with read flag.
  - 0x02 -> ADDR with write flag.
  - any other value -> IGNORE and pulse cmd_err.
- ADDR: shift 24 bits MSB-first; keep addr[ADDR_BITS-1:0]. At the 24th rise:
  - Read: load the data shift register with mem[addr] and go to READ.
  - Write: go to WRITE.
- READ:
  - On each fall, miso <= shift[7] and shift left. The first fall after the 24th address rise drives bit 7 of the first byte.
  - After the 8th fall of a byte: addr <= addr+1 mod 2^ADDR_BITS, and the shift register reloads from mem[new addr] in the same cycle.
  - Rises are ignored.
- WRITE:
  - Collect 8 mosi bits on rises.
  - On the 8th rise: mem[addr] <= byte, wr_strobe=1 for one clk, addr <= addr+1 mod 2^ADDR_BITS.
  - miso stays 0.
- IGNORE: miso=0; all edges are ignored until cs_n rises.
- MISO timing:
  - During CMD/ADDR/WRITE/IGNORE, miso=0; it changes only on falls in READ.
  - Latency from the SCLK pin fall to miso is at most SYNC_STAGES+2 clk cycles. This must be under half an SCLK period.
- Boundary conditions:
  - cs_n rising mid-byte in WRITE: the partial byte is discarded and no strobe is issued.
  - cs_n rising mid-byte in READ: the byte is abandoned.
  - A transaction ending during CMD or ADDR has no side effects.
  - The address wraps from 2^ADDR_BITS-1 to 0 for both reads and writes.
  - Simultaneous rst and activity: rst wins.
  - rst asserted mid-transaction: immediate IDLE. The next transaction begins only after a new cs_n high-to-low transition is observed after reset release.
  - A byte written and then read in the same or a later transaction returns the new value.

Test Plan:
- Reset with cs_n=1, then CS low, WRITE 0x02, address 0x000010, data 0xAA, 0x55, CS high -> exactly two wr_strobe pulses; mem[0x10]=0xAA, mem[0x11]=0x55.
- READ 0x03, address 0x000010, 16 clocks -> master samples 0xAA then 0x55; miso toggles only after falls; busy=1 throughout, then 0 after CS high.
- ADDR_BITS=8: write 0x11, 0x22 starting at address 0x0000FF -> mem[0xFF]=0x11, mem[0x00]=0x22. Read from 0x0000FF returns 0x11, 0x22.
- Command 0x9F followed by 24 clocks -> one cmd_err pulse; miso=0 throughout; no wr_strobe; memory unchanged.
- WRITE to 0x20 with data 0x3C, then 4 more bits 1010, then CS high -> one wr_strobe; mem[0x21] unchanged. Read-back of 0x20 gives 0x3C.
- rst pulsed after the 10th address bit of a READ -> miso=0 next cycle; state=IDLE. A fresh CS-low READ of 0x10 returns 0xAA.

Source files
------------

// File: rtl/spi_ram_responder_if.sv
// SPI target pin bundle plus the responder's status strobes.
// The master modport drives the SPI pins; the slave modport drives miso and status.
// No flow control: every signal is sampled or driven on clk.
interface spi_ram_responder_if;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;
    logic busy;
    logic wr_strobe;
    logic cmd_err;

    modport master (
        output sclk, cs_n, mosi,
        input  miso, busy, wr_strobe, cmd_err
    );

    modport slave (
        input  sclk, cs_n, mosi,
        output miso, busy, wr_strobe, cmd_err
    );
endinterface

// File: rtl/spi_ram_responder.sv
// SPI mode-0 RAM target (READ 0x03 / WRITE 0x02, 24-bit address, sequential) over an internal byte array.
// Latency: SCLK pin fall to miso is SYNC_STAGES+1 clk cycles; write strobes 1 clk after the synchronized 8th rise.
// Backpressure: none; the SPI master owns the pace, and clk must run at least 8x SCLK.
module spi_ram_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_ram_responder_if.slave   spi
);
    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_WR   = 8'h02;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WRITE, READ, IGNORE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   armed_q, armed_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   rd_q, rd_d;
    logic                   miso_q, miso_d;
    logic                   wr_strobe_q, wr_strobe_d;
    logic                   cmd_err_q, cmd_err_d;
    logic                   mem_we;

    logic [7:0]             mem [DEPTH];

    logic                   sclk_cur, cs_cur, mosi_cur, rise, fall;
    logic [7:0]             shift_in;
    logic [ADDR_BITS-1:0]   addr_in, addr_inc;

    assign sclk_cur = sclk_sync_q[SYNC_STAGES-1];
    assign cs_cur   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_cur = mosi_sync_q[SYNC_STAGES-1];
    assign rise     = ~sclk_prev_q & sclk_cur;
    assign fall     = sclk_prev_q & ~sclk_cur;
    assign shift_in = {shift_q[6:0], mosi_cur};
    assign addr_in  = {addr_q[ADDR_BITS-2:0], mosi_cur};
    assign addr_inc = addr_q + 1'b1;

    // Synchronizers, plus an arming flag: a transaction may only start after
    // cs_n has been seen high once the synchronizer refilled after reset.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi.cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
        fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
        sclk_prev_d = sclk_cur;
        armed_d     = armed_q | (cs_cur & fill_q[SYNC_STAGES-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            sclk_prev_q <= 1'b0;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            miso_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            fill_q      <= fill_d;
            sclk_prev_q <= sclk_prev_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            miso_q      <= miso_d;
            wr_strobe_q <= wr_strobe_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    // Backing array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[addr_q] <= shift_in;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cs_cur) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (armed_q) state_d = CMD;
                CMD:     if (rise && cnt_q == 5'd7)
                             state_d = (shift_in == CMD_READ || shift_in == CMD_WR) ? ADDR : IGNORE;
                ADDR:    if (rise && cnt_q == 5'd23) state_d = rd_q ? READ : WRITE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        miso_d      = miso_q;
        wr_strobe_d = 1'b0;
        cmd_err_d   = 1'b0;
        mem_we      = 1'b0;
        if (cs_cur) begin
            cnt_d   = '0;
            shift_d = '0;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d  = '0;
                    miso_d = 1'b0;
                end
                CMD: begin
                    miso_d = 1'b0;
                    if (rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d     = '0;
                            rd_d      = (shift_in == CMD_READ);
                            cmd_err_d = ~(shift_in == CMD_READ || shift_in == CMD_WR);
                        end
                    end
                end
                ADDR: begin
                    miso_d = 1'b0;
                    if (rise) begin
                        addr_d = addr_in;
                        cnt_d  = cnt_q + 5'd1;
                        if (cnt_q == 5'd23) begin
                            cnt_d   = '0;
                            shift_d = rd_q ? mem[addr_in] : 8'h00;
                        end
                    end
                end
                WRITE: begin
                    miso_d = 1'b0;
                    if (rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d       = '0;
                            mem_we      = 1'b1;
                            wr_strobe_d = 1'b1;
                            addr_d      = addr_inc;
                        end
                    end
                end
                READ: begin
                    if (fall) begin
                        miso_d  = shift_q[7];
                        shift_d = {shift_q[6:0], 1'b0};
                        cnt_d   = cnt_q + 5'd1;
                        // Reload in the same cycle so the next byte's MSB is ready for the next fall.
                        if (cnt_q == 5'd7) begin
                            cnt_d   = '0;
                            addr_d  = addr_inc;
                            shift_d = mem[addr_inc];
                        end
                    end
                end
                default: miso_d = 1'b0;
            endcase
        end
    end

    assign spi.miso      = miso_q;
    assign spi.busy      = ~cs_cur;
    assign spi.wr_strobe = wr_strobe_q;
    assign spi.cmd_err   = cmd_err_q;
endmodule

// File: tb/tb_spi_ram_responder.sv
// Bench for spi_ram_responder: bit-banged SPI mode-0 master with a byte-array model and a read scoreboard.
module tb_spi_ram_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_ram_responder_if bus();

    spi_ram_responder #(.ADDR_BITS(8), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .spi (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] model_mem [256];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    logic [7:0] wr_q  [$];

    int   strobe_cnt = 0;
    int   err_cnt    = 0;
    int   toggle_bad = 0;
    int   zero_bad   = 0;
    int   busy_bad   = 0;
    logic chk_zero   = 1'b0;
    logic chk_busy   = 1'b0;
    logic miso_prev  = 1'b0;

    // miso may only move while sclk is low (it follows falls); pulses counted per clk.
    always @(negedge clk) begin
        if (bus.wr_strobe === 1'b1) strobe_cnt++;
        if (bus.cmd_err === 1'b1) err_cnt++;
        if (bus.miso !== miso_prev && bus.sclk === 1'b1) toggle_bad++;
        if (chk_zero && bus.miso !== 1'b0) zero_bad++;
        if (chk_busy && bus.busy !== 1'b1) busy_bad++;
        miso_prev = bus.miso;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        wait_clk(1);
        bus.cs_n = 1'b0;
        wait_clk(4);
        chk_busy = 1'b1;
    endtask

    task automatic cs_high();
        wait_clk(4);
        chk_busy = 1'b0;
        bus.cs_n = 1'b1;
        wait_clk(6);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        bus.mosi = b;
        wait_clk(8);
        bus.sclk = 1'b1;
        r = bus.miso;
        wait_clk(8);
        bus.sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] d;
        spi_byte(cmd, d);
        spi_byte(a[23:16], d);
        spi_byte(a[15:8], d);
        spi_byte(a[7:0], d);
    endtask

    task automatic do_write(input logic [23:0] a);
        logic [7:0] d;
        logic [7:0] ma;
        cs_low();
        chk_zero = 1'b1;
        send_hdr(8'h02, a);
        for (int i = 0; i < wr_q.size(); i++) begin
            spi_byte(wr_q[i], d);
            ma = a[7:0] + 8'(i);
            model_mem[ma] = wr_q[i];
        end
        chk_zero = 1'b0;
        cs_high();
        wr_q.delete();
    endtask

    task automatic do_read(input logic [23:0] a, input int n);
        logic [7:0] rx;
        logic [7:0] ma;
        cs_low();
        send_hdr(8'h03, a);
        for (int i = 0; i < n; i++) begin
            ma = a[7:0] + 8'(i);
            exp_q.push_back(model_mem[ma]);
            spi_byte(8'h00, rx);
            got_q.push_back(rx);
        end
        cs_high();
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.cs_n = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(4);
        tests_run++;
        if (bus.miso !== 1'b0) begin tests_failed++; $display("FAIL reset_miso: got %b want 0", bus.miso); end
        tests_run++;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        tests_run++;
        if (bus.wr_strobe !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_strobe: got %b want 0", bus.wr_strobe); end
        tests_run++;
        if (bus.cmd_err !== 1'b0) begin tests_failed++; $display("FAIL reset_cmd_err: got %b want 0", bus.cmd_err); end
    endtask

    task automatic test_write();
        int s0;
        s0 = strobe_cnt;
        zero_bad = 0;
        wr_q = '{8'hAA, 8'h55};
        do_write(24'h000010);
        tests_run++;
        if (strobe_cnt - s0 !== 2) begin tests_failed++; $display("FAIL write_strobes: got %0d want 2", strobe_cnt - s0); end
        tests_run++;
        if (dut.mem[8'h10] !== 8'hAA) begin tests_failed++; $display("FAIL write_mem10: got %h want aa", dut.mem[8'h10]); end
        tests_run++;
        if (dut.mem[8'h11] !== 8'h55) begin tests_failed++; $display("FAIL write_mem11: got %h want 55", dut.mem[8'h11]); end
        tests_run++;
        if (zero_bad !== 0) begin tests_failed++; $display("FAIL write_miso_zero: got %0d nonzero samples want 0", zero_bad); end
    endtask

    task automatic test_read();
        logic [7:0] e, g;
        toggle_bad = 0;
        busy_bad   = 0;
        do_read(24'h000010, 2);
        tests_run++;
        if (got_q.size() !== 2) begin tests_failed++; $display("FAIL read_count: got %0d want 2", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL read_data: got %h want %h", g, e); end
        end
        tests_run++;
        if (toggle_bad !== 0) begin tests_failed++; $display("FAIL read_miso_timing: got %0d toggles with sclk high want 0", toggle_bad); end
        tests_run++;
        if (busy_bad !== 0) begin tests_failed++; $display("FAIL read_busy: got %0d low samples want 0", busy_bad); end
        tests_run++;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL read_busy_after_cs: got %b want 0", bus.busy); end
    endtask

    task automatic test_wrap();
        logic [7:0] e, g;
        wr_q = '{8'h11, 8'h22};
        do_write(24'h0000FF);
        tests_run++;
        if (dut.mem[8'hFF] !== 8'h11) begin tests_failed++; $display("FAIL wrap_memff: got %h want 11", dut.mem[8'hFF]); end
        tests_run++;
        if (dut.mem[8'h00] !== 8'h22) begin tests_failed++; $display("FAIL wrap_mem00: got %h want 22", dut.mem[8'h00]); end
        do_read(24'h0000FF, 2);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL wrap_read: got %h want %h", g, e); end
        end
    endtask

    task automatic test_bad_cmd();
        int s0, e0;
        logic [7:0] d;
        s0 = strobe_cnt; e0 = err_cnt; zero_bad = 0;
        cs_low();
        chk_zero = 1'b1;
        spi_byte(8'h9F, d);
        spi_byte(8'h00, d);
        spi_byte(8'h00, d);
        spi_byte(8'h10, d);
        chk_zero = 1'b0;
        cs_high();
        tests_run++;
        if (err_cnt - e0 !== 1) begin tests_failed++; $display("FAIL bad_cmd_err: got %0d want 1", err_cnt - e0); end
        tests_run++;
        if (strobe_cnt - s0 !== 0) begin tests_failed++; $display("FAIL bad_cmd_strobe: got %0d want 0", strobe_cnt - s0); end
        tests_run++;
        if (zero_bad !== 0) begin tests_failed++; $display("FAIL bad_cmd_miso: got %0d nonzero samples want 0", zero_bad); end
        tests_run++;
        if (dut.mem[8'h10] !== model_mem[8'h10]) begin tests_failed++; $display("FAIL bad_cmd_mem: got %h want %h", dut.mem[8'h10], model_mem[8'h10]); end
    endtask

    task automatic test_partial_write();
        int s0;
        logic [7:0] d;
        logic r;
        logic [7:0] e, g;
        wr_q = '{8'h00, 8'h5A};
        do_write(24'h000020);
        s0 = strobe_cnt;
        cs_low();
        send_hdr(8'h02, 24'h000020);
        spi_byte(8'h3C, d);
        spi_bit(1'b1, r); spi_bit(1'b0, r); spi_bit(1'b1, r); spi_bit(1'b0, r);
        cs_high();
        model_mem[8'h20] = 8'h3C;
        tests_run++;
        if (strobe_cnt - s0 !== 1) begin tests_failed++; $display("FAIL partial_strobe: got %0d want 1", strobe_cnt - s0); end
        tests_run++;
        if (dut.mem[8'h21] !== 8'h5A) begin tests_failed++; $display("FAIL partial_mem21: got %h want 5a", dut.mem[8'h21]); end
        do_read(24'h000020, 1);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL partial_read: got %h want %h", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        logic r;
        logic [7:0] d, e, g;
        cs_low();
        spi_byte(8'h03, d);
        for (int i = 0; i < 10; i++) spi_bit(1'b0, r);
        chk_busy = 1'b0;
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        tests_run++;
        if (bus.miso !== 1'b0) begin tests_failed++; $display("FAIL rst_addr_miso: got %b want 0", bus.miso); end
        // cs_n stays low: no new falling edge, so this write must be ignored.
        s0 = strobe_cnt;
        wait_clk(4);
        send_hdr(8'h02, 24'h000010);
        spi_byte(8'hFF, d);
        tests_run++;
        if (strobe_cnt - s0 !== 0) begin tests_failed++; $display("FAIL rst_no_rearm_strobe: got %0d want 0", strobe_cnt - s0); end
        tests_run++;
        if (dut.mem[8'h10] !== model_mem[8'h10]) begin tests_failed++; $display("FAIL rst_no_rearm_mem: got %h want %h", dut.mem[8'h10], model_mem[8'h10]); end
        cs_high();

        cs_low();
        send_hdr(8'h03, 24'h000010);
        wait_clk(6);
        tests_run++;
        if (bus.miso !== model_mem[8'h10][7]) begin tests_failed++; $display("FAIL rst_read_bit7: got %b want %b", bus.miso, model_mem[8'h10][7]); end
        chk_busy = 1'b0;
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        tests_run++;
        if (bus.miso !== 1'b0) begin tests_failed++; $display("FAIL rst_read_miso: got %b want 0", bus.miso); end
        cs_high();

        do_read(24'h000010, 1);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL rst_fresh_read: got %h want %h", g, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] a;
        logic [7:0] e, g;
        int s0;
        toggle_bad = 0;
        for (int t = 0; t < 3; t++) begin
            a = {8'($urandom_range(0, 255)), 8'h00, 8'($urandom_range(0, 255))};
            if (t == 0) a[7:0] = 8'hFE;
            for (int i = 0; i < 4; i++) wr_q.push_back(8'($urandom_range(0, 255)));
            s0 = strobe_cnt;
            do_write(a);
            tests_run++;
            if (strobe_cnt - s0 !== 4) begin tests_failed++; $display("FAIL b2b_strobes: got %0d want 4", strobe_cnt - s0); end
            do_read(a, 4);
            while (exp_q.size() > 0 && got_q.size() > 0) begin
                e = exp_q.pop_front();
                g = got_q.pop_front();
                tests_run++;
                if (g !== e) begin tests_failed++; $display("FAIL b2b_read: addr %h got %h want %h", a, g, e); end
            end
        end
        tests_run++;
        if (toggle_bad !== 0) begin tests_failed++; $display("FAIL b2b_miso_timing: got %0d want 0", toggle_bad); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_bad_cmd();
        test_partial_write();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, run incomplete");
        $fatal(1);
    end
endmodule
